// File: rtl/clint_timer_regs.sv
// clint_timer_regs: core-local interruptor registers (msip, mtimecmp, meip, mtime) behind a one-entry command buffer; define CLINT_MTIME_HI_EN to map 0xBFFC as read-only mtime_hi
module clint_timer_regs #(
  parameter int ds_width_p = 5,
  parameter int ds_ratio_p = 8
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        cmd_v_i,
  output logic        cmd_ready_o,
  input  logic        cmd_we_i,
  input  logic [15:0] cmd_addr_i,
  input  logic [63:0] cmd_wdata_i,
  output logic        resp_v_o,
  output logic        resp_we_o,
  output logic [15:0] resp_addr_o,
  output logic [63:0] resp_rdata_o,
  input  logic        resp_yumi_i,
  output logic        software_irq_o,
  output logic        timer_irq_o,
  output logic        external_irq_o
);
  localparam logic [ds_width_p-1:0] ds_reload_lp = ds_width_p'(ds_ratio_p - 1);
  logic                  full_q, full_d, we_q, msip_q, msip_d, meip_q, meip_d;
  logic [15:0]           addr_q;
  logic [63:0]           wdata_q, mtime_q, mtime_d, mtimecmp_q, mtimecmp_d;
  logic [ds_width_p-1:0] ds_q, ds_d;
  logic                  acc, deq, commit, strobe;
  logic                  sel_msip, sel_cmp, sel_meip, sel_mtime, sel_hi;
  assign acc       = cmd_v_i & ~full_q;
  assign deq       = full_q & resp_yumi_i;
  assign commit    = deq & we_q;
  assign strobe    = ds_q == '0;
  assign sel_msip  = addr_q == 16'h0000;
  assign sel_cmp   = addr_q == 16'h4000;
  assign sel_meip  = addr_q == 16'hB000;
  assign sel_mtime = addr_q == 16'hBFF8;
`ifdef CLINT_MTIME_HI_EN
  assign sel_hi    = addr_q == 16'hBFFC;
`else
  assign sel_hi    = 1'b0;
`endif
  // Next state: buffer occupancy, prescaler, and register writes committed on dequeue
  always_comb begin
    full_d     = acc ? 1'b1 : deq ? 1'b0 : full_q;
    ds_d       = strobe ? ds_reload_lp : ds_q - ds_width_p'(1);
    mtime_d    = (commit & sel_mtime) ? wdata_q : mtime_q + 64'(strobe);
    mtimecmp_d = (commit & sel_cmp) ? wdata_q : mtimecmp_q;
    msip_d     = (commit & sel_msip) ? wdata_q[0] : msip_q;
    meip_d     = (commit & sel_meip) ? wdata_q[0] : meip_q;
  end
  // State registers; reset drops any pending command
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      full_q     <= 1'b0;
      ds_q       <= ds_reload_lp;
      mtime_q    <= '0;
      mtimecmp_q <= '0;
      msip_q     <= 1'b0;
      meip_q     <= 1'b0;
    end else begin
      full_q     <= full_d;
      ds_q       <= ds_d;
      mtime_q    <= mtime_d;
      mtimecmp_q <= mtimecmp_d;
      msip_q     <= msip_d;
      meip_q     <= meip_d;
    end
  end
  // Command payload captured on accept; no reset needed since full_q qualifies it
  always_ff @(posedge clk_i) begin
    if (acc) begin
      we_q    <= cmd_we_i;
      addr_q  <= cmd_addr_i;
      wdata_q <= cmd_wdata_i;
    end
  end
  // A consume strobe with nothing buffered is a protocol error and is ignored
  always_ff @(posedge clk_i) begin
    if (!reset_i) assert (!(resp_yumi_i && !full_q));
  end
  assign cmd_ready_o    = ~full_q;
  assign resp_v_o       = full_q;
  assign resp_we_o      = we_q;
  assign resp_addr_o    = addr_q;
  assign resp_rdata_o   = ({64{sel_msip}}  & {63'b0, msip_q})
                        | ({64{sel_cmp}}   & mtimecmp_q)
                        | ({64{sel_meip}}  & {63'b0, meip_q})
                        | ({64{sel_mtime}} & mtime_q)
                        | ({64{sel_hi}}    & {32'b0, mtime_q[63:32]});
  assign software_irq_o = msip_q;
  assign external_irq_o = meip_q;
  assign timer_irq_o    = mtime_q >= mtimecmp_q;
endmodule

// File: tb/tb_clint_timer_regs.sv
// tb_clint_timer_regs: scoreboard bench for clint_timer_regs with a cycle model of the timer and registers
module tb_clint_timer_regs;
  logic        clk = 0, rst = 1;
  logic        cmd_v = 0, cmd_we = 0, resp_yumi = 0;
  logic [15:0] cmd_addr = '0;
  logic [63:0] cmd_wdata = '0;
  logic        cmd_ready_o, resp_v_o, resp_we_o, sw_irq, tm_irq, ex_irq;
  logic [15:0] resp_addr_o;
  logic [63:0] resp_rdata_o;
  int          n_tests = 0, n_fail = 0;
  typedef struct {logic we; logic [15:0] addr; logic [63:0] rdata;} exp_t;
  exp_t        sb[$];
  logic [63:0] m_mtime, m_cmp;
  logic [4:0]  m_ds;
  logic        m_msip, m_meip, m_wr = 0;
  logic [15:0] m_waddr = '0;
  logic [63:0] m_wdata = '0;

  clint_timer_regs #(.ds_width_p(5), .ds_ratio_p(8)) dut (
    .clk_i(clk), .reset_i(rst), .cmd_v_i(cmd_v), .cmd_ready_o(cmd_ready_o),
    .cmd_we_i(cmd_we), .cmd_addr_i(cmd_addr), .cmd_wdata_i(cmd_wdata),
    .resp_v_o(resp_v_o), .resp_we_o(resp_we_o), .resp_addr_o(resp_addr_o),
    .resp_rdata_o(resp_rdata_o), .resp_yumi_i(resp_yumi),
    .software_irq_o(sw_irq), .timer_irq_o(tm_irq), .external_irq_o(ex_irq));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model: prescaler of 8, mtime set beats increment, writes applied when the bench consumes a write response
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_ds <= 5'd7; m_mtime <= '0; m_cmp <= '0; m_msip <= 0; m_meip <= 0;
    end else begin
      m_ds <= (m_ds == 0) ? 5'd7 : m_ds - 5'd1;
      if (m_wr && m_waddr == 16'hBFF8) m_mtime <= m_wdata;
      else if (m_ds == 0) m_mtime <= m_mtime + 64'd1;
      if (m_wr && m_waddr == 16'h4000) m_cmp <= m_wdata;
      if (m_wr && m_waddr == 16'h0000) m_msip <= m_wdata[0];
      if (m_wr && m_waddr == 16'hB000) m_meip <= m_wdata[0];
    end
  end

  // Value the DUT should return in the cycle after a command driven now is accepted
  function automatic logic [63:0] predict(input logic [15:0] a);
    logic [63:0] mt;
    mt = (m_ds == 0) ? m_mtime + 64'd1 : m_mtime;
    case (a)
      16'h0000: return {63'b0, m_msip};
      16'h4000: return m_cmp;
      16'hB000: return {63'b0, m_meip};
      16'hBFF8: return mt;
`ifdef CLINT_MTIME_HI_EN
      16'hBFFC: return {32'b0, mt[63:32]};
`endif
      default:  return 64'd0;
    endcase
  endfunction

  // Response monitor plus per-cycle interrupt line checks
  always @(negedge clk) begin
    if (!rst) begin
      chk("timer_irq", {63'b0, tm_irq}, {63'b0, m_mtime >= m_cmp});
      chk("sw_irq", {63'b0, sw_irq}, {63'b0, m_msip});
      chk("ext_irq", {63'b0, ex_irq}, {63'b0, m_meip});
      if (resp_v_o && resp_yumi) begin
        if (sb.size() == 0) chk("sb_underflow", 64'd1, 64'd0);
        else begin
          exp_t e;
          e = sb.pop_front();
          chk("resp_we", {63'b0, resp_we_o}, {63'b0, e.we});
          chk("resp_addr", {48'b0, resp_addr_o}, {48'b0, e.addr});
          chk("resp_rdata", resp_rdata_o, e.rdata);
        end
      end
    end
  end

  task automatic do_cmd(input logic we, input logic [15:0] a, input logic [63:0] d);
    chk("cmd_ready", {63'b0, cmd_ready_o}, 64'd1);
    cmd_v = 1; cmd_we = we; cmd_addr = a; cmd_wdata = d;
    sb.push_back('{we, a, predict(a)});
    @(posedge clk); #1;
    cmd_v = 0;
    chk("resp_v", {63'b0, resp_v_o}, 64'd1);
    resp_yumi = 1; m_wr = we; m_waddr = a; m_wdata = d;
    @(posedge clk); #1;
    resp_yumi = 0; m_wr = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #1;
    chk("rst_ready", {63'b0, cmd_ready_o}, 64'd1);
    chk("rst_resp_v", {63'b0, resp_v_o}, 64'd0);
    chk("rst_timer", {63'b0, tm_irq}, 64'd1);
    chk("rst_sw", {63'b0, sw_irq}, 64'd0);
    chk("rst_ext", {63'b0, ex_irq}, 64'd0);
    @(posedge clk); #1 rst = 0;
    do_cmd(0, 16'h4000, '0);
    chk("timer_after_rst", {63'b0, tm_irq}, 64'd1);
    do_cmd(1, 16'h4000, '1);
    chk("timer_cmp_max", {63'b0, tm_irq}, 64'd0);
    idle(74);
    do_cmd(0, 16'hBFF8, '0);
    idle(14);
    do_cmd(0, 16'hBFF8, '0);
    do_cmd(1, 16'hBFF8, '1);
    idle(8);
    do_cmd(0, 16'hBFF8, '0);
    for (int i = 0; i < 16 && m_ds != 5'd1; i++) idle(1);
    do_cmd(1, 16'hBFF8, 64'h1_0000_0005);
    do_cmd(0, 16'hBFF8, '0);
    do_cmd(0, 16'hBFFC, '0);
    do_cmd(1, 16'hBFF8, 64'h1234_5678_9ABC_DEF0);
    do_cmd(0, 16'hBFFC, '0);
    do_cmd(1, 16'hBFFC, 64'hDEAD);
    do_cmd(0, 16'h0100, '0);
    do_cmd(1, 16'h0100, 64'hFFFF);
    do_cmd(0, 16'h0100, '0);
    do_cmd(0, 16'hBFF8, '0);
    do_cmd(1, 16'h0000, 64'h3);
    do_cmd(0, 16'h0000, '0);
    do_cmd(1, 16'hB000, 64'h1);
    do_cmd(0, 16'hB000, '0);
    do_cmd(1, 16'h0000, 64'h0);
    do_cmd(1, 16'hB000, 64'h0);
    do_cmd(0, 16'h0000, '0);
    do_cmd(1, 16'h4000, 64'h0);
    do_cmd(0, 16'h4000, '0);
    cmd_v = 1; cmd_we = 1; cmd_addr = 16'h0000; cmd_wdata = 64'h1;
    sb.push_back('{1'b1, 16'h0000, predict(16'h0000)});
    @(posedge clk); #1;
    cmd_addr = 16'hB000; cmd_wdata = 64'h1;
    for (int i = 0; i < 5; i++) begin
      chk("hold_ready", {63'b0, cmd_ready_o}, 64'd0);
      chk("hold_resp_v", {63'b0, resp_v_o}, 64'd1);
      chk("hold_addr", {48'b0, resp_addr_o}, 64'h0);
      chk("hold_we", {63'b0, resp_we_o}, 64'd1);
      @(posedge clk); #1;
    end
    #2 rst = 1; cmd_v = 0;
    sb.delete();
    #1;
    chk("mid_rst_resp_v", {63'b0, resp_v_o}, 64'd0);
    chk("mid_rst_ready", {63'b0, cmd_ready_o}, 64'd1);
    chk("mid_rst_timer", {63'b0, tm_irq}, 64'd1);
    chk("mid_rst_sw", {63'b0, sw_irq}, 64'd0);
    @(posedge clk); #1 rst = 0;
    do_cmd(0, 16'h0000, '0);
    do_cmd(0, 16'hB000, '0);
    do_cmd(0, 16'hBFF8, '0);
    idle(2);
    chk("sb_drained", 64'(sb.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
